alu_issue_sequencer: RTL and testbench



---
 rtl/alu_issue_sequencer.sv | 92 +++++++++
 tb/tb_alu_issue_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: decodes R-type instruction words and steps each one
// through read, execute and write-back cycles for the register-file/ALU datapath.
`default_nettype none

module alu_issue_sequencer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [ADDR_WIDTH-1:0]  rd_addr1,
  output logic [ADDR_WIDTH-1:0]  rd_addr2,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [1:0]             s,
  output logic                   wr_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    EXEC    = 3'd2,
    WRITE   = 3'd3,
    ILLEGAL = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   legal;
  logic   load;
  logic   unused_bits;

  assign legal       = (instr[6:0] == OPCODE_RTYPE);
  assign instr_ready = (state == IDLE);
  assign load        = instr_ready && instr_valid && legal;
  assign unused_bits = ^{instr[31:25], instr[14]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (instr_valid) next_state = legal ? READ : ILLEGAL;
      READ:    next_state = EXEC;
      EXEC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      ILLEGAL: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr1     <= '0;
      rd_addr2     <= '0;
      wr_addr      <= '0;
      s            <= '0;
      wr_enable    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      retire_count <= '0;
    end else begin
      if (load) begin
        rd_addr1 <= ADDR_WIDTH'(instr[19:15]);
        rd_addr2 <= ADDR_WIDTH'(instr[24:20]);
        wr_addr  <= ADDR_WIDTH'(instr[11:7]);
        s        <= instr[13:12];
      end
      wr_enable <= (next_state == WRITE);
      done      <= (next_state == WRITE);
      illegal   <= (next_state == ILLEGAL);
      busy      <= (next_state != IDLE);
      if (next_state == WRITE) retire_count <= retire_count + COUNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: table of instructions with expected
// decode, plus reset-in-flight and 4-bit counter-wrap sequences.
`default_nettype none

module tb_alu_issue_sequencer;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;

  logic        instr_ready, wr_enable, busy, done, illegal;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [1:0]  s;
  logic [15:0] retire_count;

  logic        instr_ready4, wr_enable4, busy4, done4, illegal4;
  logic [4:0]  rd_addr1_4, rd_addr2_4, wr_addr4;
  logic [1:0]  s4;
  logic [3:0]  retire_count4;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_count;
  logic [4:0]  last_rs1, last_rs2, last_rd;
  logic [1:0]  last_s;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        legal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  s;
  } vec_t;

  vec_t vecs[7];

  alu_issue_sequencer #(.ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_addr(wr_addr), .s(s), .wr_enable(wr_enable), .busy(busy), .done(done),
    .illegal(illegal), .retire_count(retire_count)
  );

  alu_issue_sequencer #(.ADDR_WIDTH(5), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready4), .rd_addr1(rd_addr1_4), .rd_addr2(rd_addr2_4),
    .wr_addr(wr_addr4), .s(s4), .wr_enable(wr_enable4), .busy(busy4), .done(done4),
    .illegal(illegal4), .retire_count(retire_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [1:0] sel);
    return {7'b0, rs2, rs1, 1'b0, sel, rd, 7'b0110011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction (valid left high) and checks every cycle until IDLE.
  task automatic run_vec(input vec_t v);
    instr       = v.instr;
    instr_valid = 1'b1;
    chk({v.name, " ready before accept"}, {31'b0, instr_ready}, 32'd1);
    tick();
    if (v.legal) begin
      chk({v.name, " rd_addr1"}, {27'b0, rd_addr1}, {27'b0, v.rs1});
      chk({v.name, " rd_addr2"}, {27'b0, rd_addr2}, {27'b0, v.rs2});
      chk({v.name, " wr_addr read"}, {27'b0, wr_addr}, {27'b0, v.rd});
      chk({v.name, " s read"}, {30'b0, s}, {30'b0, v.s});
      chk({v.name, " busy/ready/we read"}, {29'b0, busy, instr_ready, wr_enable}, 32'b100);
      tick();
      chk({v.name, " we/done exec"}, {30'b0, wr_enable, done}, 32'd0);
      chk({v.name, " rd_addr1 exec"}, {27'b0, rd_addr1}, {27'b0, v.rs1});
      tick();
      exp_count = exp_count + 16'd1;
      chk({v.name, " we/done write"}, {30'b0, wr_enable, done}, 32'b11);
      chk({v.name, " wr_addr write"}, {27'b0, wr_addr}, {27'b0, v.rd});
      chk({v.name, " s write"}, {30'b0, s}, {30'b0, v.s});
      chk({v.name, " rd_addr2 write"}, {27'b0, rd_addr2}, {27'b0, v.rs2});
      chk({v.name, " retire_count"}, {16'b0, retire_count}, {16'b0, exp_count});
      chk({v.name, " retire_count w4"}, {28'b0, retire_count4}, {28'b0, exp_count[3:0]});
      tick();
      chk({v.name, " idle after write"}, {28'b0, wr_enable, done, busy, instr_ready}, 32'b0001);
      last_rs1 = v.rs1; last_rs2 = v.rs2; last_rd = v.rd; last_s = v.s;
    end else begin
      chk({v.name, " illegal pulse"}, {29'b0, illegal, wr_enable, busy}, 32'b101);
      chk({v.name, " ready low"}, {31'b0, instr_ready}, 32'd0);
      chk({v.name, " addrs kept"}, {15'b0, rd_addr1, rd_addr2, wr_addr, s},
          {15'b0, last_rs1, last_rs2, last_rd, last_s});
      tick();
      chk({v.name, " illegal ends"}, {29'b0, illegal, wr_enable, instr_ready}, 32'b001);
      chk({v.name, " count kept"}, {16'b0, retire_count}, {16'b0, exp_count});
    end
  endtask

  initial begin
    vecs[0] = '{"add", enc(5'd10, 5'd5,  5'd6,  2'd0), 1'b1, 5'd10, 5'd5,  5'd6,  2'd0};
    vecs[1] = '{"sub", enc(5'd24, 5'd12, 5'd1,  2'd1), 1'b1, 5'd24, 5'd12, 5'd1,  2'd1};
    vecs[2] = '{"and", enc(5'd28, 5'd19, 5'd8,  2'd2), 1'b1, 5'd28, 5'd19, 5'd8,  2'd2};
    vecs[3] = '{"or",  enc(5'd17, 5'd29, 5'd30, 2'd3), 1'b1, 5'd17, 5'd29, 5'd30, 2'd3};
    vecs[4] = '{"add2", enc(5'd3, 5'd4,  5'd9,  2'd0), 1'b1, 5'd3,  5'd4,  5'd9,  2'd0};
    vecs[5] = '{"illegal", 32'h0000_0013, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0};
    vecs[6] = '{"rd0", enc(5'd31, 5'd1, 5'd0, 2'd1) | 32'hFE00_4000, 1'b1, 5'd31, 5'd1, 5'd0, 2'd1};

    exp_count = '0;
    last_rs1 = '0; last_rs2 = '0; last_rd = '0; last_s = '0;
    instr = '0;
    instr_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("reset outputs", {15'b0, rd_addr1, rd_addr2, wr_addr, s}, 32'd0);
    chk("reset strobes", {27'b0, wr_enable, busy, done, illegal, instr_ready}, 32'b00001);
    chk("reset count", {16'b0, retire_count}, 32'd0);

    // Single instruction, then idle a cycle.
    run_vec(vecs[0]);
    instr_valid = 1'b0;
    tick();
    chk("idle no accept", {30'b0, busy, instr_ready}, 32'b01);

    // Remaining table back-to-back with valid held high.
    for (int i = 1; i < 7; i++) run_vec(vecs[i]);
    instr_valid = 1'b0;
    tick();

    // Reset while an add to rd=7 is in EXEC.
    instr = enc(5'd2, 5'd3, 5'd7, 2'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("async reset we", {29'b0, wr_enable, busy, instr_ready}, 32'b001);
    chk("async reset addrs", {15'b0, rd_addr1, rd_addr2, wr_addr, s}, 32'd0);
    chk("async reset count", {16'b0, retire_count}, 32'd0);
    tick();
    chk("held reset we", {31'b0, wr_enable}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post reset idle", {29'b0, wr_enable, busy, instr_ready}, 32'b001);
    chk("post reset count", {16'b0, retire_count}, 32'd0);
    exp_count = '0;
    last_rs1 = '0; last_rs2 = '0; last_rd = '0; last_s = '0;
    run_vec(vecs[4]);

    // 4-bit counter wrap: 17 retirements after a fresh reset.
    instr_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_count = '0;
    for (int i = 0; i < 17; i++) begin
      vec_t v;
      v.name  = $sformatf("wrap%0d", i);
      v.rs1   = 5'(i);
      v.rs2   = 5'(31 - i);
      v.rd    = 5'(i + 3);
      v.s     = 2'(i);
      v.legal = 1'b1;
      v.instr = enc(v.rs1, v.rs2, v.rd, v.s);
      run_vec(v);
    end
    chk("wrap final w4", {28'b0, retire_count4}, 32'd1);
    chk("wrap final w16", {16'b0, retire_count}, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
